in_service_8259a: RTL and testbench
===================================

IN_SERVICE_8259A -- requirements
Module: in_service_8259a

Interface
REQ-001 Parameters: none; the block SHALL be fixed at 8 interrupt levels.
REQ-002 clock  in  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 interrupt_request_register  in  8  pending requests from the IRR stage.
REQ-005 interrupt_mask  in  8  1 = level masked; masked levels SHALL NOT raise interrupt or win acknowledge.
REQ-006 auto_eoi_config  in  1  1 = ISR bit cleared automatically at the second acknowledge.
REQ-007 rotate_on_auto_eoi  in  1  1 = priority rotates on each automatic EOI.
REQ-008 inta_pulse  in  1  one-cycle strobe per INTA falling edge, from the control logic.
REQ-009 eoi_strobe  in  1  one-cycle OCW2 EOI command.
REQ-010 eoi_specific  in  1  1 = specific EOI (use eoi_level); 0 = non-specific.
REQ-011 eoi_rotate  in  1  1 = rotate priority on this EOI.
REQ-012 eoi_level  in  3  target level for specific EOI.
REQ-013 interrupt  out  1  registered INT request to the CPU.
REQ-014 in_service_register  out  8  current ISR contents.
REQ-015 freeze  out  1  IRR freeze during acknowledge.
REQ-016 clear_interrupt_request  out  8  one-hot, one-cycle IRR clear.
REQ-017 vector_level  out  3  level being acknowledged.
REQ-018 vector_valid  out  1  one-cycle pulse; vector_level is valid with it.

Function
REQ-019 Priority order: lowest_priority register (3 bits); the highest level is lowest_priority+1 mod 8, descending cyclically.
REQ-020 Candidate = highest-priority bit of (interrupt_request_register & ~interrupt_mask).
REQ-021 interrupt SHALL be 1 in the cycle after a candidate exists that outranks every set ISR bit, and SHALL be 0 otherwise or while the FSM is not IDLE.
REQ-022 FSM states: IDLE, ACK1, ACK2.
REQ-023 IDLE + inta_pulse: latch the candidate into vector_level, set its ISR bit, pulse clear_interrupt_request for that level, and go to ACK1.
REQ-024 No candidate at the first inta_pulse: vector_level = 7 (spurious), no ISR set, no clear pulse.
REQ-025 ACK1 + inta_pulse: pulse vector_valid, then go to ACK2 for one cycle and then IDLE.
REQ-026 With auto_eoi_config set, the ISR bit SHALL clear on the second pulse; if rotate_on_auto_eoi, lowest_priority becomes that level.
REQ-027 freeze SHALL be 1 whenever state is ACK1 or ACK2.
REQ-028 Non-specific EOI: clear the highest-priority set ISR bit; if the ISR is empty, there is no change.
REQ-029 Specific EOI: clear bit eoi_level, including when it is already clear.
REQ-030 When eoi_rotate is set, lowest_priority SHALL become the cleared level (non-specific) or eoi_level (specific).
REQ-031 EOI and set on the same bit in the same cycle: set wins; EOI of a different bit applies in parallel.
REQ-032 inta_pulse in ACK2 SHALL be ignored.

Reset
REQ-033 Reset SHALL put the FSM in IDLE, the ISR at 8'h00, and lowest_priority at 3'd7 (IR0 highest).
REQ-034 Reset SHALL drive interrupt, freeze, clear_interrupt_request, vector_level and vector_valid to 0.
REQ-035 Reset mid-acknowledge SHALL abort to IDLE with no vector_valid and no further clear.

Structure
REQ-036 The shared package pic_8259a_pkg SHALL hold the FSM state enum, the level-count constant, and rotate-left/rotate-right helper functions.
REQ-037 A combinational sub-module priority_resolver_8259a SHALL take the request vector and lowest_priority and return the one-hot highest bit.
REQ-038 The block SHALL instantiate priority_resolver_8259a twice: once for the candidate and once for the non-specific EOI target.

Verification
REQ-039 IRR=8'h24, mask=0, two inta_pulses -> ISR=8'h04, clear=8'h04 once, vector_level=2 with vector_valid.
REQ-040 ISR=8'h04, IRR=8'h08 -> interrupt stays 0; IRR=8'h02 -> interrupt=1 next cycle.
REQ-041 ISR=8'h14, non-specific EOI with eoi_rotate -> ISR=8'h10, lowest_priority=2, so IR3 becomes highest.
REQ-042 auto_eoi_config=1, IRR=8'h80 -> ISR bit 7 set after the first pulse and clear after the second; interrupt is re-evaluated in IDLE.
REQ-043 IRR=0 at the first pulse -> vector_level=7, ISR unchanged, clear=0.
REQ-044 Reset asserted in ACK1 -> next cycle freeze=0, ISR=0, no vector_valid.

Source files
------------

// File: rtl/pic_8259a_pkg.sv
// Shared 8259A definitions: level count, acknowledge FSM states and
// cyclic rotate helpers used to turn rotating priority into fixed priority.
package pic_8259a_pkg;

  localparam int unsigned NUM_LEVELS = 8;
  localparam int unsigned LEVEL_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK1 = 2'd1,
    ST_ACK2 = 2'd2
  } state_e;

  // Result bit i takes input bit (i + n) mod 8.
  function automatic logic [NUM_LEVELS-1:0] rotate_right(input logic [NUM_LEVELS-1:0] v,
                                                         input logic [LEVEL_W-1:0]    n);
    logic [NUM_LEVELS-1:0] r;
    logic [LEVEL_W-1:0]    idx;
    r = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      idx  = LEVEL_W'(i) + n;
      r[i] = v[idx];
    end
    return r;
  endfunction

  // Result bit i takes input bit (i - n) mod 8.
  function automatic logic [NUM_LEVELS-1:0] rotate_left(input logic [NUM_LEVELS-1:0] v,
                                                        input logic [LEVEL_W-1:0]    n);
    logic [NUM_LEVELS-1:0] r;
    logic [LEVEL_W-1:0]    idx;
    r = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      idx  = LEVEL_W'(i) - n;
      r[i] = v[idx];
    end
    return r;
  endfunction

  function automatic logic [LEVEL_W-1:0] onehot_to_level(input logic [NUM_LEVELS-1:0] v);
    logic [LEVEL_W-1:0] lvl;
    lvl = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (v[i]) lvl = LEVEL_W'(i);
    end
    return lvl;
  endfunction

endpackage

// File: rtl/in_service_8259a_if.sv
// Request/acknowledge/EOI bundle between the 8259A control logic and the ISR block.
interface in_service_8259a_if;
  import pic_8259a_pkg::*;

  logic [NUM_LEVELS-1:0] interrupt_request_register;
  logic [NUM_LEVELS-1:0] interrupt_mask;
  logic                  auto_eoi_config;
  logic                  rotate_on_auto_eoi;
  logic                  inta_pulse;
  logic                  eoi_strobe;
  logic                  eoi_specific;
  logic                  eoi_rotate;
  logic [LEVEL_W-1:0]    eoi_level;
  logic                  interrupt;
  logic [NUM_LEVELS-1:0] in_service_register;
  logic                  freeze;
  logic [NUM_LEVELS-1:0] clear_interrupt_request;
  logic [LEVEL_W-1:0]    vector_level;
  logic                  vector_valid;

  modport slave (
    input  interrupt_request_register, interrupt_mask, auto_eoi_config, rotate_on_auto_eoi,
           inta_pulse, eoi_strobe, eoi_specific, eoi_rotate, eoi_level,
    output interrupt, in_service_register, freeze, clear_interrupt_request,
           vector_level, vector_valid
  );

  modport master (
    output interrupt_request_register, interrupt_mask, auto_eoi_config, rotate_on_auto_eoi,
           inta_pulse, eoi_strobe, eoi_specific, eoi_rotate, eoi_level,
    input  interrupt, in_service_register, freeze, clear_interrupt_request,
           vector_level, vector_valid
  );

endinterface

// File: rtl/priority_resolver_8259a.sv
// Picks the highest-priority set bit under rotating priority; returns it one-hot.
module priority_resolver_8259a
  import pic_8259a_pkg::*;
(
  input  logic [NUM_LEVELS-1:0] request,
  input  logic [LEVEL_W-1:0]    lowest_priority,
  output logic [NUM_LEVELS-1:0] highest_c
);

  logic [LEVEL_W-1:0]    shift;
  logic [NUM_LEVELS-1:0] rotated;
  logic [NUM_LEVELS-1:0] isolated;

  // Rotate so the top-priority level sits at bit 0, keep the lowest set bit, rotate back.
  always_comb begin
    shift     = lowest_priority + LEVEL_W'(1);
    rotated   = rotate_right(request, shift);
    isolated  = rotated & (~rotated + NUM_LEVELS'(1));
    highest_c = rotate_left(isolated, shift);
  end

endmodule

// File: rtl/in_service_8259a.sv
// 8259A in-service register: INTA acknowledge sequencing, ISR set/clear,
// EOI handling and rotating priority.
module in_service_8259a
  import pic_8259a_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  in_service_8259a_if.slave   bus
);

  state_e                state_q, state_d;
  logic [NUM_LEVELS-1:0] isr_q, isr_d;
  logic [LEVEL_W-1:0]    lowest_priority_q, lowest_priority_d;
  logic                  interrupt_q, interrupt_d;
  logic                  freeze_q, freeze_d;
  logic [NUM_LEVELS-1:0] clear_q, clear_d;
  logic [LEVEL_W-1:0]    vector_level_q, vector_level_d;
  logic                  vector_valid_q, vector_valid_d;
  logic                  ack_live_q, ack_live_d;

  logic [NUM_LEVELS-1:0] candidate_c, isr_top_c;
  logic [NUM_LEVELS-1:0] cand_rank_c, isr_rank_c;
  logic                  outranks_c;
  logic [NUM_LEVELS-1:0] set_c, eoi_clr_c, auto_clr_c;

  priority_resolver_8259a u_candidate (
    .request         (bus.interrupt_request_register & ~bus.interrupt_mask),
    .lowest_priority (lowest_priority_q),
    .highest_c       (candidate_c)
  );

  priority_resolver_8259a u_isr_top (
    .request         (isr_q),
    .lowest_priority (lowest_priority_q),
    .highest_c       (isr_top_c)
  );

  // In rotated space a lower bit position means higher priority.
  always_comb begin
    cand_rank_c = rotate_right(candidate_c, lowest_priority_q + LEVEL_W'(1));
    isr_rank_c  = rotate_right(isr_top_c, lowest_priority_q + LEVEL_W'(1));
    outranks_c  = (candidate_c != '0) && ((isr_q == '0) || (cand_rank_c < isr_rank_c));
  end

  always_comb begin
    state_d           = state_q;
    lowest_priority_d = lowest_priority_q;
    clear_d           = '0;
    vector_level_d    = vector_level_q;
    vector_valid_d    = 1'b0;
    ack_live_d        = ack_live_q;
    set_c             = '0;
    auto_clr_c        = '0;
    eoi_clr_c         = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.inta_pulse) begin
          state_d = ST_ACK1;
          if (candidate_c != '0) begin
            vector_level_d = onehot_to_level(candidate_c);
            set_c          = candidate_c;
            clear_d        = candidate_c;
            ack_live_d     = 1'b1;
          end else begin
            vector_level_d = LEVEL_W'(7);
            ack_live_d     = 1'b0;
          end
        end
      end
      ST_ACK1: begin
        if (bus.inta_pulse) begin
          state_d        = ST_ACK2;
          vector_valid_d = 1'b1;
          // A spurious acknowledge never set a bit, so it must not clear one.
          if (bus.auto_eoi_config && ack_live_q) begin
            auto_clr_c = NUM_LEVELS'(1) << vector_level_q;
            if (bus.rotate_on_auto_eoi) lowest_priority_d = vector_level_q;
          end
        end
      end
      ST_ACK2: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (bus.eoi_strobe) begin
      if (bus.eoi_specific) begin
        eoi_clr_c = NUM_LEVELS'(1) << bus.eoi_level;
        if (bus.eoi_rotate) lowest_priority_d = bus.eoi_level;
      end else if (isr_q != '0) begin
        eoi_clr_c = isr_top_c;
        if (bus.eoi_rotate) lowest_priority_d = onehot_to_level(isr_top_c);
      end
    end

    // Setting a level takes precedence over clearing it in the same cycle.
    isr_d       = (isr_q & ~(eoi_clr_c | auto_clr_c)) | set_c;
    freeze_d    = (state_d != ST_IDLE);
    interrupt_d = (state_d == ST_IDLE) && outranks_c;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      isr_q             <= '0;
      lowest_priority_q <= LEVEL_W'(7);
      interrupt_q       <= 1'b0;
      freeze_q          <= 1'b0;
      clear_q           <= '0;
      vector_level_q    <= '0;
      vector_valid_q    <= 1'b0;
      ack_live_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      isr_q             <= isr_d;
      lowest_priority_q <= lowest_priority_d;
      interrupt_q       <= interrupt_d;
      freeze_q          <= freeze_d;
      clear_q           <= clear_d;
      vector_level_q    <= vector_level_d;
      vector_valid_q    <= vector_valid_d;
      ack_live_q        <= ack_live_d;
    end
  end

  assign bus.interrupt               = interrupt_q;
  assign bus.in_service_register     = isr_q;
  assign bus.freeze                  = freeze_q;
  assign bus.clear_interrupt_request = clear_q;
  assign bus.vector_level            = vector_level_q;
  assign bus.vector_valid            = vector_valid_q;

endmodule

// File: tb/tb_in_service_8259a.sv
// Directed bench for in_service_8259a: acknowledge, EOI, rotation, auto-EOI, reset abort.
module tb_in_service_8259a;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  in_service_8259a_if bus ();

  in_service_8259a dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_inta();
    bus.inta_pulse = 1'b1;
    tick();
    bus.inta_pulse = 1'b0;
  endtask

  task automatic eoi(input logic specific, input logic rotate, input logic [2:0] level);
    bus.eoi_strobe   = 1'b1;
    bus.eoi_specific = specific;
    bus.eoi_rotate   = rotate;
    bus.eoi_level    = level;
    tick();
    bus.eoi_strobe   = 1'b0;
    bus.eoi_specific = 1'b0;
    bus.eoi_rotate   = 1'b0;
  endtask

  initial begin
    rst                            = 1'b1;
    bus.interrupt_request_register = 8'h00;
    bus.interrupt_mask             = 8'h00;
    bus.auto_eoi_config            = 1'b0;
    bus.rotate_on_auto_eoi         = 1'b0;
    bus.inta_pulse                 = 1'b0;
    bus.eoi_strobe                 = 1'b0;
    bus.eoi_specific               = 1'b0;
    bus.eoi_rotate                 = 1'b0;
    bus.eoi_level                  = 3'd0;
    tick();
    tick();
    chk("rst_interrupt", 8'(bus.interrupt), 8'h00);
    chk("rst_isr", bus.in_service_register, 8'h00);
    chk("rst_freeze", 8'(bus.freeze), 8'h00);
    chk("rst_clear", bus.clear_interrupt_request, 8'h00);
    chk("rst_vlevel", 8'(bus.vector_level), 8'h00);
    chk("rst_vvalid", 8'(bus.vector_valid), 8'h00);
    rst = 1'b0;

    // Basic acknowledge of IR2 out of {IR2, IR5}
    bus.interrupt_request_register = 8'h24;
    tick();
    chk("ack_int_raised", 8'(bus.interrupt), 8'h01);
    pulse_inta();
    chk("ack1_isr", bus.in_service_register, 8'h04);
    chk("ack1_clear", bus.clear_interrupt_request, 8'h04);
    chk("ack1_freeze", 8'(bus.freeze), 8'h01);
    chk("ack1_int_low", 8'(bus.interrupt), 8'h00);
    chk("ack1_vlevel", 8'(bus.vector_level), 8'h02);
    bus.interrupt_request_register = 8'h20;
    tick();
    chk("ack1_clear_once", bus.clear_interrupt_request, 8'h00);
    chk("ack1_no_valid", 8'(bus.vector_valid), 8'h00);
    pulse_inta();
    chk("ack2_vvalid", 8'(bus.vector_valid), 8'h01);
    chk("ack2_vlevel", 8'(bus.vector_level), 8'h02);
    chk("ack2_freeze", 8'(bus.freeze), 8'h01);
    // INTA during ACK2 must be ignored
    pulse_inta();
    chk("ack2_ign_freeze", 8'(bus.freeze), 8'h00);
    chk("ack2_ign_isr", bus.in_service_register, 8'h04);
    chk("ack2_ign_valid", 8'(bus.vector_valid), 8'h00);
    chk("ack2_ign_clear", bus.clear_interrupt_request, 8'h00);
    chk("idle_int_low", 8'(bus.interrupt), 8'h00);

    // Nesting: lower priority blocked, higher priority raises INT
    bus.interrupt_request_register = 8'h08;
    tick();
    chk("nest_low_blocked", 8'(bus.interrupt), 8'h00);
    bus.interrupt_request_register = 8'h02;
    tick();
    chk("nest_high_raise", 8'(bus.interrupt), 8'h01);

    // Acknowledge IR4 to reach ISR=14
    bus.interrupt_request_register = 8'h10;
    pulse_inta();
    chk("ir4_vlevel", 8'(bus.vector_level), 8'h04);
    bus.interrupt_request_register = 8'h00;
    pulse_inta();
    tick();
    chk("ir4_isr", bus.in_service_register, 8'h14);

    // Non-specific rotating EOI clears IR2 and makes IR3 highest
    eoi(1'b0, 1'b1, 3'd0);
    chk("ns_eoi_isr", bus.in_service_register, 8'h10);
    bus.interrupt_request_register = 8'h09;
    tick();
    chk("rot_int", 8'(bus.interrupt), 8'h01);
    pulse_inta();
    chk("rot_vlevel", 8'(bus.vector_level), 8'h03);
    chk("rot_isr", bus.in_service_register, 8'h18);
    chk("rot_clear", bus.clear_interrupt_request, 8'h08);
    bus.interrupt_request_register = 8'h00;
    pulse_inta();
    tick();

    // Specific EOI, including an already-clear level
    eoi(1'b1, 1'b0, 3'd3);
    chk("sp_eoi3", bus.in_service_register, 8'h10);
    eoi(1'b1, 1'b0, 3'd3);
    chk("sp_eoi3_again", bus.in_service_register, 8'h10);
    eoi(1'b1, 1'b0, 3'd4);
    chk("sp_eoi4", bus.in_service_register, 8'h00);

    // Set and EOI of the same bit in one cycle: set wins
    bus.interrupt_request_register = 8'h40;
    bus.eoi_strobe   = 1'b1;
    bus.eoi_specific = 1'b1;
    bus.eoi_level    = 3'd6;
    pulse_inta();
    bus.eoi_strobe   = 1'b0;
    bus.eoi_specific = 1'b0;
    chk("set_wins_isr", bus.in_service_register, 8'h40);
    bus.interrupt_request_register = 8'h00;
    pulse_inta();
    tick();
    eoi(1'b1, 1'b1, 3'd6);
    chk("sp_rot_eoi6", bus.in_service_register, 8'h00);

    // Auto-EOI without rotation on IR7
    bus.auto_eoi_config = 1'b1;
    bus.interrupt_request_register = 8'h80;
    tick();
    chk("aeoi_int", 8'(bus.interrupt), 8'h01);
    pulse_inta();
    chk("aeoi_set", bus.in_service_register, 8'h80);
    bus.interrupt_request_register = 8'h00;
    pulse_inta();
    chk("aeoi_clr", bus.in_service_register, 8'h00);
    chk("aeoi_vvalid", 8'(bus.vector_valid), 8'h01);
    chk("aeoi_vlevel", 8'(bus.vector_level), 8'h07);
    bus.interrupt_request_register = 8'h01;
    tick();
    chk("aeoi_reeval_int", 8'(bus.interrupt), 8'h01);
    chk("aeoi_reeval_freeze", 8'(bus.freeze), 8'h00);

    // Auto-EOI with rotation on IR0 makes IR1 highest
    bus.rotate_on_auto_eoi = 1'b1;
    pulse_inta();
    chk("aeoi_rot_vlevel0", 8'(bus.vector_level), 8'h00);
    bus.interrupt_request_register = 8'h00;
    pulse_inta();
    tick();
    bus.interrupt_request_register = 8'h03;
    pulse_inta();
    chk("aeoi_rot_vlevel1", 8'(bus.vector_level), 8'h01);
    bus.interrupt_request_register = 8'h00;
    pulse_inta();
    tick();
    bus.auto_eoi_config    = 1'b0;
    bus.rotate_on_auto_eoi = 1'b0;

    // Spurious acknowledge from a masked-only request
    bus.interrupt_request_register = 8'h04;
    bus.interrupt_mask             = 8'h04;
    tick();
    chk("mask_int_low", 8'(bus.interrupt), 8'h00);
    pulse_inta();
    chk("spur_vlevel", 8'(bus.vector_level), 8'h07);
    chk("spur_isr", bus.in_service_register, 8'h00);
    chk("spur_clear", bus.clear_interrupt_request, 8'h00);
    pulse_inta();
    chk("spur_vvalid", 8'(bus.vector_valid), 8'h01);
    tick();
    bus.interrupt_mask = 8'h00;

    // Reset during ACK1 aborts, and restores IR0-highest priority
    bus.interrupt_request_register = 8'h02;
    pulse_inta();
    chk("pre_rst_isr", bus.in_service_register, 8'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_freeze", 8'(bus.freeze), 8'h00);
    chk("midrst_isr", bus.in_service_register, 8'h00);
    chk("midrst_vvalid", 8'(bus.vector_valid), 8'h00);
    chk("midrst_clear", bus.clear_interrupt_request, 8'h00);
    bus.interrupt_request_register = 8'h06;
    pulse_inta();
    chk("post_rst_vlevel", 8'(bus.vector_level), 8'h01);
    chk("post_rst_vvalid", 8'(bus.vector_valid), 8'h00);
    pulse_inta();
    chk("post_rst_vvalid2", 8'(bus.vector_valid), 8'h01);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
